// File: rtl/svc_rv_dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: memory-type selectors and
// the read-response owner encoding.
package svc_rv_dmem_arb_pkg;

    localparam int MEM_TYPE_SRAM = 0;
    localparam int MEM_TYPE_BRAM = 1;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_CPU  = 2'd1,
        RSP_DBG  = 2'd2
    } rsp_own_t;

endpackage

// File: rtl/svc_rv_dmem_arb.sv
// Shares one data-memory port between the CPU MEM stage and a debug/DMA master.
// Define SVC_RV_DMEM_ARB_STATS_EN to enable the conflict_cnt statistics counter.
module svc_rv_dmem_arb
    import svc_rv_dmem_arb_pkg::*;
#(
    parameter int MEM_TYPE     = MEM_TYPE_SRAM,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_ren,
    input  logic [31:0] cpu_raddr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_waddr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_wstrb,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,

    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,

    output logic [31:0] conflict_cnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       cpu_req;
    logic       grant_dbg;
    logic       grant_cpu;
    logic [7:0] starve_cnt;
    rsp_own_t   rsp_own;
    logic [31:0] cpu_hold;
    logic       cpu_data_here;

    assign cpu_req = cpu_ren | cpu_we;

    // Grants are gated by rst_n so the memory port stays quiet while in reset.
    assign grant_dbg = rst_n & dbg_valid & (!cpu_req | (starve_cnt == LIMIT));
    assign grant_cpu = rst_n & cpu_req & !grant_dbg;

    assign dbg_ready = grant_dbg;
    assign cpu_stall = cpu_req & grant_dbg;

    always_comb begin
        mem_ren   = 1'b0;
        mem_raddr = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (grant_cpu) begin
            mem_ren   = cpu_ren;
            mem_raddr = cpu_raddr;
            mem_we    = cpu_we;
            mem_waddr = cpu_waddr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end else if (grant_dbg) begin
            mem_ren   = !dbg_we;
            mem_raddr = dbg_addr;
            mem_we    = dbg_we;
            mem_waddr = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_wstrb = dbg_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (dbg_valid && cpu_req && !grant_dbg) begin
            if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_own <= RSP_NONE;
        end else if (grant_cpu && cpu_ren) begin
            rsp_own <= RSP_CPU;
        end else if (grant_dbg && !dbg_we) begin
            rsp_own <= RSP_DBG;
        end else begin
            rsp_own <= RSP_NONE;
        end
    end

    // SRAM routes on the live grant; BRAM routes on who issued last cycle's read.
    always_comb begin
        dbg_rdata = mem_rdata;
        if (MEM_TYPE == MEM_TYPE_BRAM) begin
            dbg_rvalid    = (rsp_own == RSP_DBG);
            cpu_data_here = (rsp_own == RSP_CPU);
            cpu_rdata     = (rsp_own == RSP_CPU) ? mem_rdata : cpu_hold;
        end else begin
            dbg_rvalid    = grant_dbg & !dbg_we;
            cpu_data_here = grant_cpu & cpu_ren;
            cpu_rdata     = grant_cpu ? mem_rdata : cpu_hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold <= '0;
        end else if (cpu_data_here) begin
            cpu_hold <= mem_rdata;
        end
    end

`ifdef SVC_RV_DMEM_ARB_STATS_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (cpu_req && dbg_valid) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_svc_rv_dmem_arb.sv
// Directed bench for svc_rv_dmem_arb: an SRAM instance (STARVE_LIMIT 4) and a
// BRAM instance (STARVE_LIMIT 1) share the same requester stimulus.
module tb_svc_rv_dmem_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpu_ren = 1'b0;
    logic [31:0] cpu_raddr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_waddr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        dbg_valid = 1'b0;
    logic        dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [3:0]  dbg_wstrb = '0;

    logic [31:0] s_cpu_rdata, b_cpu_rdata;
    logic        s_cpu_stall, b_cpu_stall;
    logic        s_dbg_ready, b_dbg_ready;
    logic        s_dbg_rvalid, b_dbg_rvalid;
    logic [31:0] s_dbg_rdata, b_dbg_rdata;
    logic        s_mem_ren, b_mem_ren;
    logic [31:0] s_mem_raddr, b_mem_raddr;
    logic [31:0] s_mem_rdata, b_mem_rdata;
    logic        s_mem_we, b_mem_we;
    logic [31:0] s_mem_waddr, b_mem_waddr;
    logic [31:0] s_mem_wdata, b_mem_wdata;
    logic [3:0]  s_mem_wstrb, b_mem_wstrb;
    logic [31:0] s_conflict_cnt, b_conflict_cnt;

    logic [31:0] mem_s [0:255];
    logic [31:0] mem_b [0:255];

    int passed = 0;
    int total  = 0;

`ifdef SVC_RV_DMEM_ARB_STATS_EN
    localparam logic [31:0] EXP_CONFLICTS = 32'd10;
`else
    localparam logic [31:0] EXP_CONFLICTS = 32'd0;
`endif

    svc_rv_dmem_arb #(.MEM_TYPE(0), .STARVE_LIMIT(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_we(cpu_we),
        .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(s_dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
        .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
        .mem_ren(s_mem_ren), .mem_raddr(s_mem_raddr), .mem_rdata(s_mem_rdata),
        .mem_we(s_mem_we), .mem_waddr(s_mem_waddr), .mem_wdata(s_mem_wdata),
        .mem_wstrb(s_mem_wstrb), .conflict_cnt(s_conflict_cnt)
    );

    svc_rv_dmem_arb #(.MEM_TYPE(1), .STARVE_LIMIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_we(cpu_we),
        .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(b_dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
        .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
        .mem_ren(b_mem_ren), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
        .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .conflict_cnt(b_conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory models: SRAM reads combinationally, BRAM registers read data.
    assign s_mem_rdata = mem_s[s_mem_raddr[9:2]];

    always @(posedge clk) begin
        if (b_mem_ren) b_mem_rdata <= mem_b[b_mem_raddr[9:2]];
        for (int i = 0; i < 4; i++) begin
            if (s_mem_we && s_mem_wstrb[i]) mem_s[s_mem_waddr[9:2]][8*i +: 8] <= s_mem_wdata[8*i +: 8];
            if (b_mem_we && b_mem_wstrb[i]) mem_b[b_mem_waddr[9:2]][8*i +: 8] <= b_mem_wdata[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_ren = 1'b0; cpu_we = 1'b0; dbg_valid = 1'b0; dbg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_s[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_s[4]  = 32'hDEADBEEF;
        mem_b[8]  = 32'h11223344;
        mem_b[16] = 32'h55667788;
        b_mem_rdata = 32'h0;

        // Outputs stay quiet in reset even with both masters requesting.
        cpu_ren = 1'b1; cpu_raddr = 32'h10; dbg_valid = 1'b1; dbg_addr = 32'h10;
        #2;
        check("rst_mem_ren",   {31'b0, s_mem_ren},   32'd0);
        check("rst_cpu_stall", {31'b0, s_cpu_stall}, 32'd0);
        check("rst_dbg_ready", {31'b0, s_dbg_ready}, 32'd0);
        check("rst_dbg_rvalid",{31'b0, s_dbg_rvalid},32'd0);
        check("rst_cpu_rdata", s_cpu_rdata,          32'd0);
        check("rst_conflict",  s_conflict_cnt,       32'd0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // SRAM debug read, CPU idle.
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        #2;
        check("sram_dbg_ready",  {31'b0, s_dbg_ready},  32'd1);
        check("sram_mem_ren",    {31'b0, s_mem_ren},    32'd1);
        check("sram_mem_raddr",  s_mem_raddr,           32'h10);
        check("sram_dbg_rvalid", {31'b0, s_dbg_rvalid}, 32'd1);
        check("sram_dbg_rdata",  s_dbg_rdata,           32'hDEADBEEF);
        tick();
        idle();
        tick();

        // Starvation: forced grants on cycles 4 and 9.
        cpu_ren = 1'b1; cpu_raddr = 32'h10; dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            #2;
            check($sformatf("starve_stall_c%0d", c), {31'b0, s_cpu_stall}, {31'b0, (c == 4 || c == 9)});
            check($sformatf("starve_ready_c%0d", c), {31'b0, s_dbg_ready}, {31'b0, (c == 4 || c == 9)});
            if (c == 4) check("starve_hold_rdata", s_cpu_rdata, 32'hDEADBEEF);
            tick();
        end
        idle();
        #2;
        check("conflict_cnt", s_conflict_cnt, EXP_CONFLICTS);
        tick();

        // dbg_valid dropping mid-wait clears the counter.
        cpu_ren = 1'b1; dbg_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("drop_pre_ready_c%0d", c), {31'b0, s_dbg_ready}, 32'd0);
            tick();
        end
        dbg_valid = 1'b0;
        #2;
        check("drop_gap_stall", {31'b0, s_cpu_stall}, 32'd0);
        tick();
        dbg_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("drop_post_ready_c%0d", c), {31'b0, s_dbg_ready}, {31'b0, (c == 4)});
            tick();
        end
        idle();
        tick();

        // BRAM: CPU load at n, forced dbg read at n+1, dbg response at n+2.
        cpu_ren = 1'b1; cpu_raddr = 32'h20; dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        #2;
        check("bram_n_ready", {31'b0, b_dbg_ready}, 32'd0);
        check("bram_n_stall", {31'b0, b_cpu_stall}, 32'd0);
        tick();
        #2;
        check("bram_n1_ready",  {31'b0, b_dbg_ready},  32'd1);
        check("bram_n1_stall",  {31'b0, b_cpu_stall},  32'd1);
        check("bram_n1_rdata",  b_cpu_rdata,           32'h11223344);
        check("bram_n1_rvalid", {31'b0, b_dbg_rvalid}, 32'd0);
        tick();
        idle();
        #2;
        check("bram_n2_rvalid",   {31'b0, b_dbg_rvalid}, 32'd1);
        check("bram_n2_dbg_rdata", b_dbg_rdata,          32'h55667788);
        check("bram_n2_cpu_rdata", b_cpu_rdata,          32'h11223344);
        tick();
        tick();

        // Concurrent stores: CPU first, then dbg when CPU idles.
        cpu_we = 1'b1; cpu_waddr = 32'h8; cpu_wdata = 32'hA5A5A5A5; cpu_wstrb = 4'h3;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'hC; dbg_wdata = 32'h12345678; dbg_wstrb = 4'hF;
        #2;
        check("st_cpu_we",    {31'b0, s_mem_we},    32'd1);
        check("st_cpu_waddr", s_mem_waddr,          32'h8);
        check("st_cpu_wdata", s_mem_wdata,          32'hA5A5A5A5);
        check("st_cpu_wstrb", {28'b0, s_mem_wstrb}, 32'h3);
        check("st_cpu_ready", {31'b0, s_dbg_ready}, 32'd0);
        tick();
        cpu_we = 1'b0;
        #2;
        check("st_dbg_ready", {31'b0, s_dbg_ready}, 32'd1);
        check("st_dbg_we",    {31'b0, s_mem_we},    32'd1);
        check("st_dbg_ren",   {31'b0, s_mem_ren},   32'd0);
        check("st_dbg_waddr", s_mem_waddr,          32'hC);
        check("st_dbg_wstrb", {28'b0, s_mem_wstrb}, 32'hF);
        tick();
        idle();
        tick();
        check("st_mem_word2", mem_s[2], 32'h0000A5A5);
        check("st_mem_word3", mem_s[3], 32'h12345678);

        // Reset mid-cycle with a BRAM dbg read outstanding.
        cpu_ren = 1'b1; cpu_raddr = 32'h20; dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        tick();
        #2;
        check("rr_dbg_granted", {31'b0, b_dbg_ready}, 32'd1);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("rr_async_rvalid",  {31'b0, b_dbg_rvalid}, 32'd0);
        check("rr_async_rdata",   b_cpu_rdata,           32'd0);
        check("rr_async_starve",  {24'b0, dut_s.starve_cnt}, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        #2;
        check("rr_post_rvalid", {31'b0, b_dbg_rvalid}, 32'd0);
        check("rr_post_rdata",  b_cpu_rdata,           32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
